// File: rtl/adder_acc_pkg.sv
// ============================================================================
// Module   : adder_acc_pkg
// Purpose  : Shared constants for the adder_accumulator slice: datapath width,
//            FSM state encodings and saturation values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_acc_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ACC  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [3:0] SAT_POS = 4'b0111;
    localparam logic [3:0] SAT_NEG = 4'b1000;

    // Saturation target on overflow: only two negatives can overflow negative.
    function automatic logic [3:0] sat_value(input logic a_msb, input logic b_msb);
        return (a_msb & b_msb) ? SAT_NEG : SAT_POS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_accumulator_fa4.sv
// ============================================================================
// Module   : FullAdder4bit
// Purpose  : 4-bit ripple-carry adder with carry-out and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module FullAdder4bit
    import adder_acc_pkg::*;
(
    output logic [3:0] sum,
    output logic       carryout,
    output logic       overflow,
    input  logic [3:0] a,
    input  logic [3:0] b
);

    logic       w_carry;
    logic       w_carry_msb;

    // Ripple chain kept in one block; carry into the MSB feeds the overflow test.
    always_comb begin
        w_carry     = 1'b0;
        w_carry_msb = 1'b0;
        sum         = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                w_carry_msb = w_carry;
            end
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
    end

    assign carryout = w_carry;
    assign overflow = w_carry ^ w_carry_msb;

endmodule

`default_nettype wire

// File: rtl/adder_accumulator.sv
// ============================================================================
// Module   : adder_accumulator
// Purpose  : Folds a counted stream of 4-bit operands into a running sum via
//            FullAdder4bit; optional saturation under ADDER_ACC_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_accumulator
    import adder_acc_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAX_OPS = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] op_count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] C_MAX_OPS = CNT_W'(MAX_OPS);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_co;
    logic             add_ovf;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_start;

    FullAdder4bit u_adder (
        .sum      (add_sum),
        .carryout (add_co),
        .overflow (add_ovf),
        .a        (acc_q),
        .b        (in_data)
    );

`ifdef ADDER_ACC_SAT_EN
    assign acc_next = add_ovf ? sat_value(acc_q[WIDTH-1], in_data[WIDTH-1]) : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign cnt_start = (op_count > C_MAX_OPS) ? C_MAX_OPS : op_count;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d   = cnt_start;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = (cnt_start == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    acc_d   = acc_next;
                    carry_d = carry_q | add_co;
                    ovf_d   = ovf_q | add_ovf;
                    cnt_d   = cnt_q - C_ONE;
                    if (cnt_q == C_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result fields are gated so nothing but a finished run is ever visible.
    assign in_ready  = (state_q == ST_ACC);
    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_sum   = res_valid ? acc_q : '0;
    assign res_carry = res_valid & carry_q;
    assign res_ovf   = res_valid & ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_accumulator.sv
// ============================================================================
// Module   : tb_adder_accumulator
// Purpose  : Directed self-checking bench for adder_accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] op_count;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_sum;
    logic       res_carry;
    logic       res_ovf;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    adder_accumulator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_count  (op_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers are entered and left just after a falling edge.
    task automatic begin_run(input logic [3:0] n);
        start    = 1'b1;
        op_count = n;
        @(negedge clk);
        start    = 1'b0;
        op_count = 4'd0;
    endtask

    task automatic send(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'd0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        obs = {res_valid, res_sum, res_carry, res_ovf, in_ready, busy};
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b exp %b", obs, 9'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {res_valid, res_sum, res_carry, res_ovf, in_ready, busy};
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b exp %b", obs, 9'b0);
        end
    endtask

    task automatic test_carry_wrap();
        logic [6:0] obs;
        begin_run(4'd2);
        n_checks++;
        if ({in_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL t1_enter_acc: got %b exp 11", {in_ready, busy});
        end
        send(4'b1111);
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_early_valid: got %b exp 0", res_valid);
        end
        send(4'b0001);
        obs = {res_valid, res_sum, res_carry, res_ovf};
        n_checks++;
        if (obs !== 7'b1_0000_1_0) begin
            n_fail++;
            $display("FAIL t1_result: got %b exp %b", obs, 7'b1_0000_1_0);
        end
        drain();
        n_checks++;
        if ({res_valid, busy, in_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL t1_back_to_idle: got %b exp 000", {res_valid, busy, in_ready});
        end
    endtask

    task automatic test_overflow();
        logic [6:0] obs;
        logic [6:0] exp;
`ifdef ADDER_ACC_SAT_EN
        exp = 7'b1_0111_0_1;
`else
        exp = 7'b1_1001_0_1;
`endif
        begin_run(4'd3);
        send(4'b0111);
        send(4'b0001);
        send(4'b0001);
        obs = {res_valid, res_sum, res_carry, res_ovf};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL t2_overflow: got %b exp %b", obs, exp);
        end
        drain();
    endtask

    task automatic test_stall();
        logic [6:0] obs;
        logic [6:0] exp;
`ifdef ADDER_ACC_SAT_EN
        exp = 7'b1_1000_1_1;
`else
        exp = 7'b1_0001_1_1;
`endif
        begin_run(4'd2);
        send(4'b1000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({in_ready, res_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL t3_gap%0d: got %b exp 10", i, {in_ready, res_valid});
            end
        end
        send(4'b1001);
        obs = {res_valid, res_sum, res_carry, res_ovf};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL t3_result: got %b exp %b", obs, exp);
        end
        drain();
    endtask

    task automatic test_done_hold();
        logic [7:0] obs;
        begin_run(4'd2);
        send(4'b0011);
        send(4'b0100);
        for (int i = 0; i < 5; i++) begin
            obs = {res_valid, res_sum, res_carry, res_ovf, busy};
            n_checks++;
            if (obs !== 8'b1_0111_0_0_1) begin
                n_fail++;
                $display("FAIL t4_hold%0d: got %b exp %b", i, obs, 8'b1_0111_0_0_1);
            end
            if (i == 2) begin
                start    = 1'b1;
                op_count = 4'd2;
            end
            @(negedge clk);
            start    = 1'b0;
            op_count = 4'd0;
        end
        drain();
        n_checks++;
        if ({res_valid, in_ready, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL t4_release: got %b exp 000", {res_valid, in_ready, busy});
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] obs;
        in_valid = 1'b1;
        in_data  = 4'b0101;
        begin_run(4'd0);
        obs = {res_valid, res_sum, res_carry, res_ovf, in_ready};
        n_checks++;
        if (obs !== 8'b1_0000_0_0_0) begin
            n_fail++;
            $display("FAIL t5_zero_count: got %b exp %b", obs, 8'b1_0000_0_0_0);
        end
        in_valid = 1'b0;
        in_data  = 4'd0;
        drain();
    endtask

    task automatic test_clamp();
        logic [6:0] obs;
        logic [6:0] exp;
`ifdef ADDER_ACC_SAT_EN
        exp = 7'b1_0111_0_1;
`else
        exp = 7'b1_1000_0_1;
`endif
        begin_run(4'd15);
        for (int i = 0; i < 7; i++) begin
            send(4'b0001);
        end
        n_checks++;
        if ({in_ready, res_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL clamp_after7: got %b exp 10", {in_ready, res_valid});
        end
        send(4'b0001);
        obs = {res_valid, res_sum, res_carry, res_ovf};
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL clamp_result: got %b exp %b", obs, exp);
        end
        drain();
    endtask

    task automatic test_reset_midrun();
        logic [8:0] obs;
        logic [6:0] res;
        begin_run(4'd3);
        send(4'b0101);
        #2 rst_n = 1'b0;
        #1;
        obs = {res_valid, res_sum, res_carry, res_ovf, in_ready, busy};
        n_checks++;
        if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL t6_async_reset: got %b exp %b", obs, 9'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin_run(4'd2);
        send(4'b0010);
        send(4'b0011);
        res = {res_valid, res_sum, res_carry, res_ovf};
        n_checks++;
        if (res !== 7'b1_0101_0_0) begin
            n_fail++;
            $display("FAIL t6_fresh_run: got %b exp %b", res, 7'b1_0101_0_0);
        end
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        op_count  = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        res_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_stall();
        test_done_hold();
        test_zero_count();
        test_clamp();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
